// File: rtl/btn_event_pkg.sv
// Shared state encoding, parameter defaults and counter sizing for the button event decoder.
package btn_event_pkg;

  localparam int LONG_CYCLES_DEF = 50_000_000;
  localparam int GAP_CYCLES_DEF  = 25_000_000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_GAP    = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  function automatic int cnt_width(input int long_cycles, input int gap_cycles);
    return $clog2(((long_cycles > gap_cycles) ? long_cycles : gap_cycles) + 1);
  endfunction

endpackage

// File: rtl/btn_evt_timer.sv
// Saturating up-counter with synchronous clear and a terminal-count flag (cnt >= limit).
module btn_evt_timer
  import btn_event_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic             tc
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  assign tc = (cnt >= limit);

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies debounced button activity into short, long and double press pulses.
// Define BTN_DOUBLE_PRESS_EN to build the GAP/PRESS2 double-press path.
module btn_event_decoder
  import btn_event_pkg::*;
#(
  parameter int LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_db,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);

  // state  | meaning
  // IDLE   | waiting for a press edge
  // PRESS1 | first press in progress, counting high samples
  // GAP    | released after a short first press, counting low samples
  // PRESS2 | second press in progress, counting high samples
  // HOLD   | event already reported, waiting for release

  localparam int CNT_W = cnt_width(LONG_CYCLES, GAP_CYCLES);
  // The sample that enters a phase is its first; tc means the current sample is the N-th.
  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYCLES - 2);
`ifdef BTN_DOUBLE_PRESS_EN
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYCLES - 2);
`endif

  state_e           state_q, state_d;
  logic             btn_q;
  logic             tmr_clr, tmr_inc, tmr_tc;
  logic [CNT_W-1:0] tmr_limit;
  logic             short_d, long_d;
`ifdef BTN_DOUBLE_PRESS_EN
  logic             double_d;
`endif

  btn_evt_timer #(.WIDTH(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .inc   (tmr_inc),
    .limit (tmr_limit),
    .tc    (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    tmr_limit = LONG_LIM;
    short_d   = 1'b0;
    long_d    = 1'b0;
`ifdef BTN_DOUBLE_PRESS_EN
    double_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (btn_db && !btn_q) begin
          state_d = ST_PRESS1;
          tmr_clr = 1'b1;
        end
      end
      ST_PRESS1: begin
        if (btn_db) begin
          if (tmr_tc) begin
            long_d  = 1'b1;
            state_d = ST_HOLD;
          end else begin
            tmr_inc = 1'b1;
          end
        end else begin
`ifdef BTN_DOUBLE_PRESS_EN
          state_d = ST_GAP;
          tmr_clr = 1'b1;
`else
          short_d = 1'b1;
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef BTN_DOUBLE_PRESS_EN
      ST_GAP: begin
        tmr_limit = GAP_LIM;
        if (btn_db) begin
          state_d = ST_PRESS2;
          tmr_clr = 1'b1;
        end else if (tmr_tc) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (btn_db) begin
          if (tmr_tc) begin
            double_d = 1'b1;
            state_d  = ST_HOLD;
          end else begin
            tmr_inc = 1'b1;
          end
        end else begin
          double_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
`endif
      ST_HOLD: begin
        if (!btn_db) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // btn_q resets high so a button already held at reset release is not seen as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      btn_q       <= 1'b1;
      short_press <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_q       <= btn_db;
      short_press <= short_d;
      long_press  <= long_d;
    end
  end

`ifdef BTN_DOUBLE_PRESS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      double_press <= 1'b0;
    end else begin
      double_press <= double_d;
    end
  end
`else
  assign double_press = 1'b0;
`endif

  assign busy = (state_q != ST_IDLE);

endmodule
